// File: rtl/hdmi_init_sequencer.sv
// Power-up / hot-plug register loader for the HDMI transmitter: walks a register
// table and issues one I2C write per entry, retrying NACKed writes.
module hdmi_init_sequencer #(
   parameter int         PWR_DELAY = 2500000,
   parameter int         NUM_REGS  = 31,
   parameter logic [7:0] DEV_ADDR  = 8'h72,
   parameter int         MAX_RETRY = 3,
   parameter int         RETRY_GAP = 250
) (
   input  logic        clock_25,
   input  logic        reset,
   input  logic        interrupt,
   output logic [5:0]  tbl_addr,
   input  logic [15:0] tbl_data,
   output logic        i2c_req,
   output logic [7:0]  i2c_dev_addr,
   output logic [7:0]  i2c_reg_addr,
   output logic [7:0]  i2c_wdata,
   input  logic        i2c_done,
   input  logic        i2c_nack,
   output logic        config_done,
   output logic        config_error,
   output logic [7:0]  pass_count
);

   localparam int CNT_MAX = (PWR_DELAY > RETRY_GAP) ? PWR_DELAY : RETRY_GAP;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int RTY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   localparam logic [CNT_W-1:0] PWR_LAST    = CNT_W'(PWR_DELAY - 1);
   localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(RETRY_GAP - 1);
   localparam logic [RTY_W-1:0] RETRY_LIMIT = RTY_W'(MAX_RETRY);
   localparam logic [5:0]       LAST_ENTRY  = 6'(NUM_REGS - 1);

   typedef enum logic [2:0] {
      PWR_WAIT,
      LOAD,
      REQ,
      GAP,
      NEXT,
      DONE,
      FAIL
   } state_t;

   state_t           state_reg,    state_next;
   logic [CNT_W-1:0] delay_reg,    delay_next;
   logic [RTY_W-1:0] retry_reg,    retry_next;
   logic [5:0]       tbl_addr_reg, tbl_addr_next;
   logic [7:0]       reg_addr_reg, reg_addr_next;
   logic [7:0]       wdata_reg,    wdata_next;
   logic             req_reg,      req_next;
   logic             done_reg,     done_next;
   logic             error_reg,    error_next;
   logic [7:0]       pass_reg,     pass_next;
   logic             pending_reg,  pending_next;
   logic             sync1_reg, sync2_reg, sync3_reg;
   logic             irq_edge;

   always_ff @(posedge clock_25 or negedge reset) begin
      if (!reset) begin
         state_reg    <= PWR_WAIT;
         delay_reg    <= '0;
         retry_reg    <= '0;
         tbl_addr_reg <= '0;
         reg_addr_reg <= '0;
         wdata_reg    <= '0;
         req_reg      <= 1'b0;
         done_reg     <= 1'b0;
         error_reg    <= 1'b0;
         pass_reg     <= '0;
         pending_reg  <= 1'b0;
         sync1_reg    <= 1'b0;
         sync2_reg    <= 1'b0;
         sync3_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         delay_reg    <= delay_next;
         retry_reg    <= retry_next;
         tbl_addr_reg <= tbl_addr_next;
         reg_addr_reg <= reg_addr_next;
         wdata_reg    <= wdata_next;
         req_reg      <= req_next;
         done_reg     <= done_next;
         error_reg    <= error_next;
         pass_reg     <= pass_next;
         pending_reg  <= pending_next;
         sync1_reg    <= interrupt;
         sync2_reg    <= sync1_reg;
         sync3_reg    <= sync2_reg;
      end
   end

   // sync3_reg only holds the previous synchronised level for edge detection
   assign irq_edge = sync2_reg & ~sync3_reg;

   always_comb begin
      state_next    = state_reg;
      delay_next    = delay_reg;
      retry_next    = retry_reg;
      tbl_addr_next = tbl_addr_reg;
      reg_addr_next = reg_addr_reg;
      wdata_next    = wdata_reg;
      req_next      = 1'b0;
      done_next     = done_reg;
      error_next    = error_reg;
      pass_next     = pass_reg;
      pending_next  = pending_reg | irq_edge;

      case (state_reg)
         PWR_WAIT: begin
            if (delay_reg == PWR_LAST) begin
               delay_next = '0;
               state_next = LOAD;
            end else begin
               delay_next = delay_reg + CNT_W'(1);
            end
         end
         LOAD: begin
            reg_addr_next = tbl_data[15:8];
            wdata_next    = tbl_data[7:0];
            retry_next    = '0;
            req_next      = 1'b1;
            state_next    = REQ;
         end
         // req is registered from the next state, so it is high exactly while in REQ
         REQ: begin
            req_next = 1'b1;
            if (i2c_done) begin
               req_next = 1'b0;
               if (!i2c_nack) begin
                  state_next = NEXT;
               end else if (retry_reg < RETRY_LIMIT) begin
                  retry_next = retry_reg + RTY_W'(1);
                  state_next = GAP;
               end else begin
                  error_next    = 1'b1;
                  done_next     = 1'b0;
                  tbl_addr_next = '0;
                  state_next    = FAIL;
               end
            end
         end
         GAP: begin
            if (delay_reg == GAP_LAST) begin
               delay_next = '0;
               req_next   = 1'b1;
               state_next = REQ;
            end else begin
               delay_next = delay_reg + CNT_W'(1);
            end
         end
         NEXT: begin
            if (tbl_addr_reg == LAST_ENTRY) begin
               tbl_addr_next = '0;
               done_next     = 1'b1;
               if (pass_reg != 8'hFF) begin
                  pass_next = pass_reg + 8'd1;
               end
               state_next = DONE;
            end else begin
               tbl_addr_next = tbl_addr_reg + 6'd1;
               state_next    = LOAD;
            end
         end
         DONE, FAIL: begin
            // an edge landing on the restart cycle is kept so it triggers another pass
            if (pending_reg) begin
               done_next     = 1'b0;
               error_next    = 1'b0;
               pending_next  = irq_edge;
               tbl_addr_next = '0;
               state_next    = LOAD;
            end
         end
         default: begin
            state_next = PWR_WAIT;
         end
      endcase
   end

   assign tbl_addr     = tbl_addr_reg;
   assign i2c_req      = req_reg;
   assign i2c_dev_addr = DEV_ADDR;
   assign i2c_reg_addr = reg_addr_reg;
   assign i2c_wdata    = wdata_reg;
   assign config_done  = done_reg;
   assign config_error = error_reg;
   assign pass_count   = pass_reg;

endmodule

// File: tb/tb_hdmi_init_sequencer.sv
// Bench for hdmi_init_sequencer: an I2C master responder logs every write and a
// table-level model predicts the write sequence, retries and final status.
module tb_hdmi_init_sequencer;

   localparam int         PWR_DELAY = 10;
   localparam int         NUM_REGS  = 3;
   localparam logic [7:0] DEV_ADDR  = 8'h72;
   localparam int         MAX_RETRY = 3;
   localparam int         RETRY_GAP = 4;

   logic        clock_25 = 1'b0;
   logic        reset = 1'b0;
   logic        interrupt = 1'b0;
   logic [5:0]  tbl_addr;
   logic [15:0] tbl_data;
   logic        i2c_req;
   logic [7:0]  i2c_dev_addr;
   logic [7:0]  i2c_reg_addr;
   logic [7:0]  i2c_wdata;
   logic        i2c_done = 1'b0;
   logic        i2c_nack = 1'b0;
   logic        config_done;
   logic        config_error;
   logic [7:0]  pass_count;

   hdmi_init_sequencer #(
      .PWR_DELAY(PWR_DELAY),
      .NUM_REGS (NUM_REGS),
      .DEV_ADDR (DEV_ADDR),
      .MAX_RETRY(MAX_RETRY),
      .RETRY_GAP(RETRY_GAP)
   ) dut (
      .clock_25    (clock_25),
      .reset       (reset),
      .interrupt   (interrupt),
      .tbl_addr    (tbl_addr),
      .tbl_data    (tbl_data),
      .i2c_req     (i2c_req),
      .i2c_dev_addr(i2c_dev_addr),
      .i2c_reg_addr(i2c_reg_addr),
      .i2c_wdata   (i2c_wdata),
      .i2c_done    (i2c_done),
      .i2c_nack    (i2c_nack),
      .config_done (config_done),
      .config_error(config_error),
      .pass_count  (pass_count)
   );

   always #5 clock_25 = ~clock_25;

   logic [15:0] rom [64];
   assign tbl_data = rom[tbl_addr];

   typedef struct {
      logic [7:0] dev;
      logic [7:0] ra;
      logic [7:0] dat;
      int         idle;
   } wr_t;

   typedef struct {
      logic [7:0] ra;
      logic [7:0] dat;
      logic       nack;
   } exp_t;

   wr_t  log_q[$];
   exp_t exp_q[$];
   bit   nack_q[$];

   int n_assert = 0;
   int n_fail   = 0;
   int exp_pass = 0;
   bit exp_err  = 0;
   int nack_sched [NUM_REGS];
   int ack_delay  = 5;
   int stab_err   = 0;

   // I2C master responder: answers each request after ack_delay cycles (0 = random)
   wr_t cur;
   bit  active = 0;
   bit  cur_nack = 0;
   int  wait_cnt = 0;
   int  idle = 0;
   always @(negedge clock_25) begin
      i2c_done = 1'b0;
      i2c_nack = 1'b0;
      if (reset !== 1'b1) begin
         active = 0;
         idle   = 0;
      end else if (i2c_req === 1'b1) begin
         if (!active) begin
            active   = 1;
            cur.dev  = i2c_dev_addr;
            cur.ra   = i2c_reg_addr;
            cur.dat  = i2c_wdata;
            cur.idle = idle;
            log_q.push_back(cur);
            cur_nack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
            wait_cnt = (ack_delay == 0) ? int'($urandom_range(8, 1)) - 1 : ack_delay - 1;
         end else if (i2c_reg_addr !== cur.ra || i2c_wdata !== cur.dat) begin
            stab_err++;
         end
         if (wait_cnt == 0) begin
            i2c_done = 1'b1;
            i2c_nack = cur_nack;
         end
         wait_cnt--;
         idle = 0;
      end else begin
         active = 0;
         idle++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock_25);
   endtask

   // Reference model: expands the table and NACK schedule into the expected attempts
   task automatic build_exp();
      exp_t e;
      exp_err = 0;
      for (int i = 0; i < NUM_REGS; i++) begin
         for (int a = 0; a <= MAX_RETRY; a++) begin
            e.ra   = rom[i][15:8];
            e.dat  = rom[i][7:0];
            e.nack = (a < nack_sched[i]);
            exp_q.push_back(e);
            nack_q.push_back(e.nack);
            if (!e.nack) break;
         end
         if (nack_sched[i] > MAX_RETRY) begin
            exp_err = 1;
            break;
         end
      end
      if (!exp_err && exp_pass < 255) exp_pass++;
   endtask

   task automatic new_pass(input bit randomize_tbl);
      log_q.delete();
      exp_q.delete();
      nack_q.delete();
      for (int i = 0; i < NUM_REGS; i++) begin
         if (randomize_tbl) begin
            rom[i]        = 16'($urandom);
            nack_sched[i] = ($urandom_range(3, 0) == 0) ? int'($urandom_range(4, 1)) : 0;
         end
      end
      build_exp();
   endtask

   task automatic check_log(input string tag);
      chk({tag, "_count"}, log_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
         chk({tag, "_dev"}, log_q[i].dev, DEV_ADDR);
         chk({tag, "_reg"}, log_q[i].ra, exp_q[i].ra);
         chk({tag, "_data"}, log_q[i].dat, exp_q[i].dat);
         if (i > 0 && exp_q[i-1].nack) chk({tag, "_gap"}, log_q[i].idle >= RETRY_GAP, 1);
      end
   endtask

   task automatic check_status(input string tag);
      chk({tag, "_done"}, config_done, !exp_err);
      chk({tag, "_error"}, config_error, exp_err);
      chk({tag, "_pass"}, pass_count, exp_pass);
      chk({tag, "_tbl_addr"}, tbl_addr, 0);
      chk({tag, "_req_idle"}, i2c_req, 0);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_req"}, i2c_req, 0);
      chk({tag, "_tbl_addr"}, tbl_addr, 0);
      chk({tag, "_reg_addr"}, i2c_reg_addr, 0);
      chk({tag, "_wdata"}, i2c_wdata, 0);
      chk({tag, "_done"}, config_done, 0);
      chk({tag, "_error"}, config_error, 0);
      chk({tag, "_pass"}, pass_count, 0);
      chk({tag, "_dev_addr"}, i2c_dev_addr, DEV_ADDR);
   endtask

   // Called at a negedge with reset low: releases it and measures cycles to first request
   task automatic release_and_time(input string tag);
      int n;
      reset = 1'b1;
      n = 0;
      while (n < 100) begin
         @(negedge clock_25);
         n++;
         if (i2c_req === 1'b1) break;
      end
      chk(tag, n, PWR_DELAY + 1);
   endtask

   task automatic trigger();
      int n;
      @(negedge clock_25);
      interrupt = 1'b1;
      @(negedge clock_25);
      interrupt = 1'b0;
      n = 1;
      while ((config_done || config_error) && n < 20) begin
         @(negedge clock_25);
         n++;
      end
      chk("restart_latency", n <= 4, 1);
   endtask

   task automatic wait_result(input string tag);
      int n;
      n = 0;
      while (!(config_done || config_error) && n < 3000) begin
         @(negedge clock_25);
         n++;
      end
      chk({tag, "_timeout"}, n < 3000, 1);
      tick(2);
   endtask

   initial begin
      int n;
      int sz;
      for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
      rom[0] = 16'h4110;
      rom[1] = 16'h9803;
      rom[2] = 16'h9AE0;
      for (int i = 0; i < NUM_REGS; i++) nack_sched[i] = 0;

      // Power-up
      tick(3);
      check_reset_vals("reset");
      new_pass(0);
      ack_delay = 5;
      release_and_time("first_req_latency");
      wait_result("powerup");
      check_log("powerup");
      check_status("powerup");

      // NACK recovery on entry 1
      nack_sched[1] = 2;
      new_pass(0);
      trigger();
      wait_result("nack_recover");
      check_log("nack_recover");
      check_status("nack_recover");

      // Retry exhaustion on entry 2
      nack_sched[1] = 0;
      nack_sched[2] = 9;
      new_pass(0);
      trigger();
      wait_result("exhaust");
      sz = log_q.size();
      tick(40);
      check_log("exhaust");
      check_status("exhaust");
      chk("exhaust_no_more_writes", log_q.size(), sz);

      // Re-trigger from FAIL
      nack_sched[2] = 0;
      new_pass(0);
      trigger();
      wait_result("from_fail");
      check_log("from_fail");
      check_status("from_fail");

      // Random tables, NACK patterns and ack delays
      ack_delay = 0;
      for (int p = 0; p < 8; p++) begin
         new_pass(1);
         trigger();
         wait_result("random");
         check_log("random");
         check_status("random");
      end

      // Two interrupt edges during entry 1: one restart pass only
      rom[0] = 16'h4110;
      rom[1] = 16'h9803;
      rom[2] = 16'h9AE0;
      for (int i = 0; i < NUM_REGS; i++) nack_sched[i] = 0;
      ack_delay = 12;
      new_pass(0);
      build_exp();
      trigger();
      n = 0;
      while (log_q.size() < 2 && n < 500) begin
         @(negedge clock_25);
         n++;
      end
      chk("midpass_reach_entry1", n < 500, 1);
      interrupt = 1'b1;
      tick(1);
      interrupt = 1'b0;
      tick(2);
      interrupt = 1'b1;
      tick(1);
      interrupt = 1'b0;
      n = 0;
      while (!(log_q.size() >= 6 && config_done) && n < 3000) begin
         @(negedge clock_25);
         n++;
      end
      chk("midpass_timeout", n < 3000, 1);
      tick(60);
      check_log("midpass");
      check_status("midpass");

      // pass_count saturation
      ack_delay = 1;
      for (int p = 0; p < 256; p++) begin
         new_pass(0);
         trigger();
         wait_result("saturate");
      end
      chk("saturate_pass", pass_count, 255);
      chk("saturate_model", exp_pass, 255);

      // Reset while a write is outstanding
      ack_delay = 12;
      new_pass(0);
      trigger();
      n = 0;
      while (i2c_req !== 1'b1 && n < 100) begin
         @(negedge clock_25);
         n++;
      end
      chk("midreset_req_seen", n < 100, 1);
      #2 reset = 1'b0;
      #1 check_reset_vals("midreset");
      @(negedge clock_25);
      exp_pass = 0;
      ack_delay = 5;
      new_pass(0);
      release_and_time("reset_req_latency");
      wait_result("after_reset");
      check_log("after_reset");
      check_status("after_reset");

      chk("req_stable_while_high", stab_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not complete, observed running expected finished");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/hdmi_init_sequencer.md
Name: hdmi_init_sequencer

Overview:
- Sequences the HDMI transmitter's register configuration after power-up, and again whenever the transmitter raises its interrupt line (hot-plug/monitor-sense events).
- Walks an external register table (combinational ROM) and issues one I2C write per entry to a byte-level I2C write master through a req/done handshake.
- Retries NACKed writes, then reports done/error status.
- Sits between the top level (clock_25, transmitter interrupt) and the I2C master that drives I2C_SCL/I2C_SDA.

Parameters:
- PWR_DELAY, 2500000: clock_25 cycles to wait after reset before the first write (100 ms at 25 MHz).
- NUM_REGS, 31: number of table entries, 1..64.
- DEV_ADDR, 8'h72: 8-bit I2C write address of the transmitter.
- MAX_RETRY, 3: retries per entry after a NACK; the total attempt limit is MAX_RETRY+1.
- RETRY_GAP, 250: idle cycles between a NACK and the retry.

Ports:
- clock_25, in, 1: pixel/system clock; all state changes on its rising edge.
- reset, in, 1: asynchronous, active-low reset.
- interrupt, in, 1: transmitter interrupt, asynchronous, active-high; synchronised internally.
- tbl_addr, out, 6: table index.
- tbl_data, in, 16: [15:8] register address, [7:0] data; combinational from tbl_addr, valid in the same cycle.
- i2c_req, out, 1: write request to the I2C master.
- i2c_dev_addr, out, 8: device address, always DEV_ADDR.
- i2c_reg_addr, out, 8: register address of the current write.
- i2c_wdata, out, 8: data byte of the current write.
- i2c_done, in, 1: one-cycle pulse when the master finishes a write.
- i2c_nack, in, 1: qualified by i2c_done; 1 means the write was NACKed.
- config_done, out, 1: the last pass completed without error.
- config_error, out, 1: an entry exhausted its retries.
- pass_count, out, 8: completed passes, saturating at 255.

Behaviour:
- **Reset values** (reset low, asynchronous): i2c_req=0, tbl_addr=0, i2c_reg_addr=0, i2c_wdata=0, config_done=0, config_error=0, pass_count=0, state=PWR_WAIT, delay counter=0, retry counter=0, interrupt pending=0, synchroniser flops=0.
- **i2c_dev_addr** is the constant DEV_ADDR.
- **Interrupt input**:
  - Two-flop synchroniser, then a rising-edge detect on the synchronised signal.
  - An edge sets the pending flag in any state.
  - The pending flag clears when a new pass starts.
- **PWR_WAIT**:
  - Counter increments each cycle.
  - When the counter equals PWR_DELAY-1, go to LOAD and clear the counter.
  - The first i2c_req rises PWR_DELAY+1 cycles after reset deasserts.
- **LOAD**:
  - Register tbl_data[15:8] into i2c_reg_addr and tbl_data[7:0] into i2c_wdata.
  - Clear the retry counter; go to REQ.
- **REQ**:
  - Assert i2c_req and hold it; i2c_reg_addr and i2c_wdata stay stable while i2c_req=1.
  - Wait for i2c_done. On the done cycle, drop i2c_req on the next edge.
    - i2c_nack=0: go to NEXT.
    - i2c_nack=1 and retry counter < MAX_RETRY: increment the retry counter, go to GAP.
    - i2c_nack=1 and retry counter = MAX_RETRY: go to FAIL.
  - i2c_done while i2c_req=0 is ignored.
- **GAP**: wait RETRY_GAP cycles, then go to REQ with the same address and data.
- **NEXT**:
  - If tbl_addr = NUM_REGS-1: tbl_addr=0, go to DONE.
  - Else: tbl_addr+1, go to LOAD.
- **DONE**:
  - Set config_done=1, increment pass_count (saturating at 255).
  - If pending is set, or is set in a later cycle: clear config_done and config_error, clear pending, tbl_addr=0, go to LOAD. There is no power delay on re-trigger.
- **FAIL**:
  - Set config_error=1, tbl_addr=0, pass_count unchanged.
  - A pending interrupt restarts exactly as from DONE.
- **Interrupt mid-pass** (PWR_WAIT, LOAD, REQ, GAP, NEXT):
  - The current write is never aborted.
  - pending is held, so the pass finishes or fails first, then restarts immediately from DONE/FAIL.
  - Multiple edges collapse into one restart.
- **Simultaneous i2c_done and interrupt edge**: both take effect; the handshake resolves normally and pending is set.
- **Reset mid-transaction**: i2c_req drops asynchronously, the sequencer returns to PWR_WAIT, and the full delay reapplies.

Test Plan:
- Power-up: PWR_DELAY=10, NUM_REGS=3, table {41_10, 98_03, 9A_E0}, master acks every request 5 cycles after i2c_req rises -> first i2c_req 11 cycles after reset release; writes (72,41,10), (72,98,03), (72,9A,E0) in order; config_done=1, pass_count=1.
- NACK recovery: entry 1 NACKed twice then acked, MAX_RETRY=3, RETRY_GAP=4 -> three requests for 98/03, each ≥4 idle cycles apart; pass completes; config_error=0.
- Retry exhaustion: entry 2 always NACKed -> exactly 4 attempts for 9A/E0; config_error=1, config_done=0, i2c_req stays 0 afterward.
- Interrupt re-trigger: after DONE, pulse interrupt for 1 cycle -> LOAD within 4 cycles, no power delay; config_done clears; all 3 writes repeat; pass_count=2.
- Interrupt mid-write plus reset: interrupt edge pulsed twice during entry 1 -> current pass finishes, exactly one restart pass follows. Then assert reset while i2c_req=1 -> i2c_req=0 immediately, all outputs at reset values, restart after the full PWR_DELAY.
